// File: rtl/score_keeper.sv
// Match score keeper: goal detection from ball X, score counting, and the idle/play/pause/over FSM.
// Optional build macro SCORE_BCD_EN selects packed-BCD score outputs instead of plain binary.
module score_keeper #(
  parameter int X_POS_W      = 11,
  parameter int SCREEN_H_RES = 640,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int CNT_W        = $clog2(PAUSE_CYCLES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic [7:0]         player_score_o,
  output logic [7:0]         pc_score_o,
  output logic               goal_o,
  output logic               freeze_o,
  output logic               game_over_o,
  output logic               winner_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [X_POS_W-1:0] H_RES        = X_POS_W'(SCREEN_H_RES);
  localparam logic [CNT_W-1:0]   PAUSE_RELOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [7:0]         WIN_BIN      = 8'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};

`ifdef SCORE_BCD_EN
  // BCD increment with units carry, holding at 99.
  function automatic logic [7:0] score_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99) begin
      r = s;
    end else if (s[3:0] >= 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] score_bin(input logic [7:0] s);
    return ({4'd0, s[7:4]} * 8'd10) + {4'd0, s[3:0]};
  endfunction
`else
  function automatic logic [7:0] score_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s >= 8'd99) begin
      r = s;
    end else begin
      r = s + 8'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] score_bin(input logic [7:0] s);
    return s;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ps_q, ps_d, pc_q, pc_d;
  logic             goal_q, goal_d;
  logic             freeze_q, freeze_d;
  logic             over_q, over_d;
  logic             winner_q, winner_d;
  logic             out_q, out_d;

  logic       out_r, out_l, out_now, goal_evt;
  logic [7:0] ps_inc, pc_inc;

  always_comb begin
    out_r    = (ball_x_i > H_RES);
    out_l    = (ball_x_i == {X_POS_W{1'b0}});
    out_now  = out_r | out_l;
    goal_evt = (state_q == ST_PLAY) & out_now & ~out_q;
    ps_inc   = score_inc(ps_q);
    pc_inc   = score_inc(pc_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    pc_d     = pc_q;
    goal_d   = 1'b0;
    freeze_d = freeze_q;
    over_d   = over_q;
    winner_d = winner_q;
    out_d    = out_now;

    case (state_q)
      ST_IDLE: begin
        over_d   = 1'b0;
        winner_d = 1'b0;
        if (start_i) begin
          state_d  = ST_PLAY;
          freeze_d = 1'b0;
        end else begin
          freeze_d = 1'b1;
        end
      end
      ST_PLAY: begin
        over_d = 1'b0;
        if (goal_evt) begin
          goal_d   = 1'b1;
          freeze_d = 1'b1;
          // Left exit is a player point, right exit a pc point; both cannot hold at once.
          if (out_l) begin
            ps_d = ps_inc;
            if (score_bin(ps_inc) == WIN_BIN) begin
              state_d  = ST_OVER;
              over_d   = 1'b1;
              winner_d = 1'b1;
            end else begin
              state_d = ST_PAUSE;
              cnt_d   = PAUSE_RELOAD;
            end
          end else begin
            pc_d = pc_inc;
            if (score_bin(pc_inc) == WIN_BIN) begin
              state_d  = ST_OVER;
              over_d   = 1'b1;
              winner_d = 1'b0;
            end else begin
              state_d = ST_PAUSE;
              cnt_d   = PAUSE_RELOAD;
            end
          end
        end else begin
          freeze_d = 1'b0;
        end
      end
      ST_PAUSE: begin
        over_d = 1'b0;
        if (cnt_q == CNT_ZERO) begin
          state_d  = ST_PLAY;
          freeze_d = 1'b0;
        end else begin
          cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          freeze_d = 1'b1;
        end
      end
      ST_OVER: begin
        if (start_i) begin
          state_d  = ST_PLAY;
          ps_d     = 8'd0;
          pc_d     = 8'd0;
          winner_d = 1'b0;
          over_d   = 1'b0;
          freeze_d = 1'b0;
        end else begin
          over_d   = 1'b1;
          freeze_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = CNT_ZERO;
        ps_d     = 8'd0;
        pc_d     = 8'd0;
        freeze_d = 1'b1;
        over_d   = 1'b0;
        winner_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      ps_q     <= 8'd0;
      pc_q     <= 8'd0;
      goal_q   <= 1'b0;
      freeze_q <= 1'b1;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      pc_q     <= pc_d;
      goal_q   <= goal_d;
      freeze_q <= freeze_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      out_q    <= out_d;
    end
  end

  assign player_score_o = ps_q;
  assign pc_score_o     = pc_q;
  assign goal_o         = goal_q;
  assign freeze_o       = freeze_q;
  assign game_over_o    = over_q;
  assign winner_o       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Table-driven bench for score_keeper (WIN_SCORE=3, PAUSE_CYCLES=4) plus a WIN_SCORE=12 instance
// for the two-digit score case and hand sequences for asynchronous reset.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [10:0] bx, bx2;
  logic [7:0]  ps, pc, ps2, pc2;
  logic        goal, frz, over, win;
  logic        goal2, frz2, over2, win2;

  always #5 clk = ~clk;

  score_keeper #(.X_POS_W(11), .SCREEN_H_RES(640), .WIN_SCORE(3), .PAUSE_CYCLES(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ball_x_i(bx),
    .player_score_o(ps), .pc_score_o(pc), .goal_o(goal), .freeze_o(frz),
    .game_over_o(over), .winner_o(win)
  );

  score_keeper #(.X_POS_W(11), .SCREEN_H_RES(640), .WIN_SCORE(12), .PAUSE_CYCLES(2)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .ball_x_i(bx2),
    .player_score_o(ps2), .pc_score_o(pc2), .goal_o(goal2), .freeze_o(frz2),
    .game_over_o(over2), .winner_o(win2)
  );

  typedef struct {
    logic        start;
    logic [10:0] x;
    logic        goal;
    logic        frz;
    logic        over;
    logic        win;
    logic [7:0]  ps;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic [10:0] x, input logic g, input logic f,
                      input logic o, input logic w, input logic [7:0] p, input logic [7:0] c);
    vec_t v;
    v.start = s; v.x = x; v.goal = g; v.frz = f; v.over = o; v.win = w; v.ps = p; v.pc = c;
    vecs.push_back(v);
  endtask

  // Four frozen cycles follow a goal: three more with freeze held, then back to play.
  task automatic pause_rows(input logic s, input logic [10:0] x, input logic [7:0] p, input logic [7:0] c);
    for (int i = 0; i < 3; i++) push(s, x, 1'b0, 1'b1, 1'b0, 1'b0, p, c);
    push(s, x, 1'b0, 1'b0, 1'b0, 1'b0, p, c);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_freeze"}, {7'd0, frz}, 8'd1);
    chk({tag, "_ps"}, ps, 8'd0);
    chk({tag, "_pc"}, pc, 8'd0);
    chk({tag, "_goal"}, {7'd0, goal}, 8'd0);
    chk({tag, "_over"}, {7'd0, over}, 8'd0);
    chk({tag, "_winner"}, {7'd0, win}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bx = 11'd320; start2 = 1'b0; bx2 = 11'd320;
    #12;
    chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    // Idle with no start, then start.
    for (int i = 0; i < 10; i++) push(1'b0, 11'd320, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    push(1'b1, 11'd320, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    push(1'b0, 11'd320, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // Left exit held for 20 cycles: one goal only.
    push(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
    pause_rows(1'b0, 11'd0, 8'd1, 8'd0);
    for (int i = 0; i < 15; i++) push(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    // Right exit at 641 scores, 640 is in bounds.
    push(1'b0, 11'd320, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
    push(1'b0, 11'd641, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    pause_rows(1'b0, 11'd641, 8'd1, 8'd1);
    push(1'b0, 11'd640, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    push(1'b0, 11'd640, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    push(1'b0, 11'd320, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    // Player reaches 3 and wins; goals ignored in OVER.
    push(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);
    pause_rows(1'b0, 11'd320, 8'd2, 8'd1);
    push(1'b0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 8'd1);
    push(1'b0, 11'd641, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 8'd1);
    push(1'b0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 8'd1);
    push(1'b0, 11'd320, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 8'd1);
    // Restart with the ball already out: no goal on re-entry.
    push(1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    push(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    push(1'b0, 11'd320, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // PC wins while start is held high during play and pause.
    push(1'b1, 11'd641, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
    pause_rows(1'b1, 11'd320, 8'd0, 8'd1);
    push(1'b1, 11'd641, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2);
    pause_rows(1'b0, 11'd320, 8'd0, 8'd2);
    push(1'b0, 11'd641, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3);
    push(1'b0, 11'd641, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd3);

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start;
      bx    = vecs[i].x;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_goal", i), {7'd0, goal}, {7'd0, vecs[i].goal});
      chk($sformatf("v%0d_freeze", i), {7'd0, frz}, {7'd0, vecs[i].frz});
      chk($sformatf("v%0d_over", i), {7'd0, over}, {7'd0, vecs[i].over});
      chk($sformatf("v%0d_winner", i), {7'd0, win}, {7'd0, vecs[i].win});
      chk($sformatf("v%0d_ps", i), ps, vecs[i].ps);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
    end

    // Two-digit score on the WIN_SCORE=12 instance.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int g = 1; g <= 12; g++) begin
      @(negedge clk) bx2 = 11'd0;
      @(posedge clk);
      #1;
      chk($sformatf("w12_goal%0d", g), {7'd0, goal2}, 8'd1);
      if (g == 10) begin
`ifdef SCORE_BCD_EN
        chk("w12_ten", ps2, 8'h10);
`else
        chk("w12_ten", ps2, 8'd10);
`endif
        chk("w12_ten_over", {7'd0, over2}, 8'd0);
      end
      @(negedge clk) bx2 = 11'd320;
      repeat (2) @(posedge clk);
    end
    #1;
    chk("w12_over", {7'd0, over2}, 8'd1);
    chk("w12_winner", {7'd0, win2}, 8'd1);
`ifdef SCORE_BCD_EN
    chk("w12_final", ps2, 8'h12);
`else
    chk("w12_final", ps2, 8'd12);
`endif

    // Asynchronous reset with the pause counter at 2.
    @(negedge clk) begin start = 1'b0; bx = 11'd320; rst_n = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) bx = 11'd0;
    @(posedge clk);
    #1;
    chk("ar_goal_pulse", {7'd0, goal}, 8'd1);
    chk("ar_ps", ps, 8'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("ar_pause");
    @(posedge clk);
    #1;
    chk("ar_held_goal", {7'd0, goal}, 8'd0);

    // Asynchronous reset in the goal-pulse cycle.
    @(negedge clk) begin rst_n = 1'b1; bx = 11'd320; end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) bx = 11'd641;
    @(posedge clk);
    #1;
    chk("ag_goal_pulse", {7'd0, goal}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("ag");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
